// File: rtl/run_mon_pkg.sv
// run_mon_pkg: shared types and helpers for the pipeline run monitor.
//   run_state_t  : monitor FSM states (IDLE, RUN, PASS, FAIL)
//   fail_code_t  : reported failure reason (FC_NONE, FC_TIMEOUT, FC_HANG)
//   sat_inc32    : 32-bit increment that sticks at all-ones
package run_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_TIMEOUT = 2'd1,
        FC_HANG    = 2'd2
    } fail_code_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_run_monitor_watch.sv
// pc_watch_channel: one PC watchpoint channel.
//   clk, reset  : core clock, synchronous active-high reset
//   active      : sample this cycle (monitor running, enabled, not exiting)
//   pc, addr    : current fetch pc and the watched address
//   hit         : registered pc==addr from the last active cycle
//   hit_count   : number of active cycles with pc==addr, saturating at all-ones
module pc_watch_channel #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned HIT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  addr,
    output logic             hit,
    output logic [HIT_W-1:0] hit_count
);

    logic             r_hit;
    logic [HIT_W-1:0] r_cnt;
    logic             w_match;

    assign w_match = (pc == addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit <= 1'b0;
            r_cnt <= '0;
        end else if (active) begin
            r_hit <= w_match;
            if (w_match && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign hit       = r_hit;
    assign hit_count = r_cnt;

endmodule

// File: rtl/pipeline_run_monitor.sv
// pipeline_run_monitor: run-control monitor for the pipelined MIPS core.
// Watches the fetch pc and writeback taps, ends the run with PASS when pc
// reaches HALT_PC, or FAIL on timeout / pc hang, and counts run cycles,
// retired register writes and per-channel PC watchpoint hits.
//   clk, reset        : core clock, synchronous active-high reset
//   en                : 1 = monitor active, 0 = hold everything
//   pc                : fetch-stage pc
//   pcnext, instr,
//   alu_out_m         : trace-only taps
//   reg_write_w,
//   write_reg_w       : WB-stage write enable and destination register
//   watch_addr        : NUM_WATCH watch PCs, channel i at [i*XLEN +: XLEN]
//   done/pass/fail    : sticky run result flags
//   fail_code         : 0 none, 1 timeout, 2 hang
//   cycle_count       : RUN cycles elapsed (saturating)
//   retire_count      : WB writes to non-zero registers (saturating)
//   watch_hit         : per-channel registered pc match, 0 outside RUN
//   hit_count         : per-channel hit totals, channel i at [i*HIT_W +: HIT_W]
// Optional macro RUN_TRACE_EN: enables simulation-only $display tracing.
module pipeline_run_monitor #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] HALT_PC        = 'h58,
    parameter int unsigned     TIMEOUT_CYCLES = 4096,
    parameter int unsigned     STALL_LIMIT    = 16,
    parameter int unsigned     NUM_WATCH      = 4,
    parameter int unsigned     HIT_W          = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            pcnext,
    input  logic [XLEN-1:0]            instr,
    input  logic [XLEN-1:0]            alu_out_m,
    input  logic                       reg_write_w,
    input  logic [4:0]                 write_reg_w,
    input  logic [NUM_WATCH*XLEN-1:0]  watch_addr,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [31:0]                cycle_count,
    output logic [31:0]                retire_count,
    output logic [NUM_WATCH-1:0]       watch_hit,
    output logic [NUM_WATCH*HIT_W-1:0] hit_count
);

    import run_mon_pkg::*;

    // Stall counter only has to reach STALL_LIMIT-1.
    localparam int unsigned SW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

    run_state_t     r_state;
    fail_code_t     r_fail_code;
    logic           r_done;
    logic           r_pass;
    logic           r_fail;
    logic [31:0]    r_cycle;
    logic [31:0]    r_retire;
    logic [XLEN-1:0] r_pc_q;
    logic [SW-1:0]  r_stall;

    logic           w_step;
    logic           w_first;
    logic           w_halt;
    logic           w_same;
    logic           w_hang;
    logic           w_timeout;
    logic           w_exit;
    logic           w_active;
    logic           w_retire;
    logic [NUM_WATCH-1:0] w_ch_hit;

    assign w_step    = (r_state == RUN) && en;
    // cycle_count saturates and never wraps, so zero marks the first RUN sample
    // (pc_q not yet loaded).
    assign w_first   = (r_cycle == '0);
    assign w_halt    = (pc == HALT_PC);
    assign w_same    = !w_first && (pc == r_pc_q);
    assign w_hang    = w_same && !w_halt && (r_stall == SW'(STALL_LIMIT - 1));
    assign w_timeout = (r_cycle == 32'(TIMEOUT_CYCLES - 1));
    assign w_exit    = w_halt || w_hang || w_timeout;
    // The exit edge itself does not count: counters freeze at the values that
    // triggered the exit.
    assign w_active  = w_step && !w_exit;
    assign w_retire  = reg_write_w && (write_reg_w != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_fail_code <= FC_NONE;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_cycle     <= '0;
            r_retire    <= '0;
            r_pc_q      <= '0;
            r_stall     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (w_halt) begin
                            r_state <= PASS;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else if (w_hang) begin
                            r_state     <= FAIL;
                            r_done      <= 1'b1;
                            r_fail      <= 1'b1;
                            r_fail_code <= FC_HANG;
                        end else if (w_timeout) begin
                            r_state     <= FAIL;
                            r_done      <= 1'b1;
                            r_fail      <= 1'b1;
                            r_fail_code <= FC_TIMEOUT;
                        end else begin
                            r_cycle <= sat_inc32(r_cycle);
                            if (w_retire) begin
                                r_retire <= sat_inc32(r_retire);
                            end
                            r_pc_q  <= pc;
                            r_stall <= w_same ? r_stall + 1'b1 : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_WATCH; g++) begin : g_watch
        pc_watch_channel #(
            .XLEN  (XLEN),
            .HIT_W (HIT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .active    (w_active),
            .pc        (pc),
            .addr      (watch_addr[g*XLEN +: XLEN]),
            .hit       (w_ch_hit[g]),
            .hit_count (hit_count[g*HIT_W +: HIT_W])
        );
    end

    assign done         = r_done;
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign fail_code    = r_fail_code;
    assign cycle_count  = r_cycle;
    assign retire_count = r_retire;
    // Channels hold their last match; terminal states report no hits.
    assign watch_hit    = w_ch_hit & {NUM_WATCH{r_state == RUN}};

`ifdef RUN_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && w_step) begin
            $display("[%0t] pc=%h pcnext=%h instr=%h alu_out_m=%h rw=%0b wr=%0d",
                     $time, pc, pcnext, instr, alu_out_m, reg_write_w, write_reg_w);
            if (w_halt) begin
                $display("RUN PASS cycles=%0d retired=%0d", r_cycle, r_retire);
            end else if (w_hang || w_timeout) begin
                $display("RUN FAIL code=%0d cycles=%0d retired=%0d",
                         w_hang ? 2 : 1, r_cycle, r_retire);
            end
        end
    end
`else
    logic w_unused_trace;
    assign w_unused_trace = ^{pcnext, instr, alu_out_m};
`endif

endmodule

// File: tb/tb_pipeline_run_monitor.sv
`timescale 1ns/1ps
module tb_pipeline_run_monitor;

    localparam int unsigned NW   = 4;
    localparam logic [31:0] HALT = 32'h58;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic [31:0]     pc = '0, pcnext = '0, instr = '0, alu_out_m = '0;
    logic            reg_write_w = 1'b0;
    logic [4:0]      write_reg_w = '0;
    logic [NW*32-1:0] watch_addr = '0;

    logic            a_done, a_pass, a_fail;
    logic [1:0]      a_fail_code;
    logic [31:0]     a_cycle, a_retire;
    logic [NW-1:0]   a_watch_hit;
    logic [NW*16-1:0] a_hit_count;

    logic            b_done, b_pass, b_fail;
    logic [1:0]      b_fail_code;
    logic [31:0]     b_cycle, b_retire;
    logic [NW-1:0]   b_watch_hit;
    logic [NW*2-1:0] b_hit_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    pipeline_run_monitor u_dut (
        .clk(clk), .reset(reset), .en(en), .pc(pc), .pcnext(pcnext), .instr(instr),
        .alu_out_m(alu_out_m), .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
        .watch_addr(watch_addr), .done(a_done), .pass(a_pass), .fail(a_fail),
        .fail_code(a_fail_code), .cycle_count(a_cycle), .retire_count(a_retire),
        .watch_hit(a_watch_hit), .hit_count(a_hit_count)
    );

    pipeline_run_monitor #(
        .TIMEOUT_CYCLES (8),
        .HIT_W          (2)
    ) u_dut_small (
        .clk(clk), .reset(reset), .en(en), .pc(pc), .pcnext(pcnext), .instr(instr),
        .alu_out_m(alu_out_m), .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
        .watch_addr(watch_addr), .done(b_done), .pass(b_pass), .fail(b_fail),
        .fail_code(b_fail_code), .cycle_count(b_cycle), .retire_count(b_retire),
        .watch_hit(b_watch_hit), .hit_count(b_hit_count)
    );

    // Reference model of u_dut (default parameters). The run is described by
    // the list of accepted pc samples; cycle_count is simply its length.
    int               m_st;      // 0 idle, 1 running, 2 passed, 3 failed
    int               m_code;
    logic [31:0]      m_hist[$];
    int unsigned      m_ret;
    int unsigned      m_hits[NW];
    logic [NW-1:0]    m_whit;

    task automatic model_edge();
        bit hang;
        if (reset) begin
            m_st = 0; m_code = 0; m_hist.delete(); m_ret = 0; m_whit = '0;
            for (int i = 0; i < NW; i++) m_hits[i] = 0;
            return;
        end
        if (m_st == 0) begin
            if (en) m_st = 1;
        end else if (m_st == 1 && en) begin
            // hang: the last 16 accepted samples all equal the current pc
            hang = 0;
            if (m_hist.size() >= 16) begin
                hang = 1;
                for (int i = 1; i <= 16; i++)
                    if (m_hist[m_hist.size() - i] != pc) hang = 0;
            end
            if (pc == HALT) begin
                m_st = 2;
            end else if (hang) begin
                m_st = 3; m_code = 2;
            end else if (m_hist.size() == 4095) begin
                m_st = 3; m_code = 1;
            end else begin
                m_hist.push_back(pc);
                if (reg_write_w && write_reg_w != 0) m_ret++;
                for (int i = 0; i < NW; i++) begin
                    m_whit[i] = (pc == watch_addr[i*32 +: 32]);
                    if (m_whit[i]) m_hits[i]++;
                end
            end
        end
    endtask

    task automatic step(input logic [31:0] p, input logic e, input logic rw, input logic [4:0] wr);
        reset = 1'b0; pc = p; en = e; reg_write_w = rw; write_reg_w = wr;
        pcnext = p + 32'd4; instr = $urandom; alu_out_m = $urandom;
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0;
        model_edge();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        watch_addr = {32'h0, 32'h0, 32'h8, 32'h4};
        step(32'h0, 1'b1, 1'b0, 5'd0);
        for (int k = 0; k < 5; k++) step(32'(4 * k), 1'b1, 1'b1, 5'd3);
        do_reset();
        total++; if ({a_done, a_pass, a_fail, a_fail_code} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {a_done, a_pass, a_fail, a_fail_code}); end
        total++; if (a_cycle !== 32'd0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", a_cycle); end
        total++; if (a_retire !== 32'd0) begin bad++; $display("FAIL reset_retire got=%0d exp=0", a_retire); end
        total++; if (a_watch_hit !== '0) begin bad++; $display("FAIL reset_watch_hit got=%b exp=0", a_watch_hit); end
        total++; if (a_hit_count !== '0) begin bad++; $display("FAIL reset_hit_count got=%h exp=0", a_hit_count); end
        // stays idle while en=0
        step(32'h0, 1'b0, 1'b1, 5'd3);
        step(32'h4, 1'b0, 1'b1, 5'd3);
        total++; if (a_cycle !== 32'd0 || a_retire !== 32'd0) begin bad++; $display("FAIL idle_hold got=%0d/%0d exp=0/0", a_cycle, a_retire); end
    endtask

    task automatic test_halt();
        do_reset();
        watch_addr = '0;
        step(32'h0, 1'b1, 1'b0, 5'd0);
        for (int k = 0; k <= 22; k++) begin
            step(32'(4 * k), 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            if (k == 21) begin
                total++; if (a_done !== 1'b0 || a_cycle !== 32'd22) begin bad++; $display("FAIL halt_pre got done=%b cyc=%0d exp done=0 cyc=22", a_done, a_cycle); end
            end
        end
        total++; if ({a_done, a_pass, a_fail, a_fail_code} !== 5'b11000) begin bad++; $display("FAIL halt_flags got=%b exp=11000", {a_done, a_pass, a_fail, a_fail_code}); end
        total++; if (a_cycle !== 32'd22) begin bad++; $display("FAIL halt_cycle got=%0d exp=22", a_cycle); end
        total++; if (a_retire !== 32'(m_ret)) begin bad++; $display("FAIL halt_retire got=%0d exp=%0d", a_retire, m_ret); end
        step(32'h100, 1'b1, 1'b1, 5'd1);
        step(32'h104, 1'b1, 1'b1, 5'd1);
        total++; if (a_cycle !== 32'd22 || a_pass !== 1'b1 || a_retire !== 32'(m_ret)) begin bad++; $display("FAIL halt_frozen got cyc=%0d pass=%b ret=%0d exp 22/1/%0d", a_cycle, a_pass, a_retire, m_ret); end
    endtask

    task automatic test_hang();
        do_reset();
        step(32'h0, 1'b1, 1'b0, 5'd0);
        for (int k = 1; k <= 17; k++) begin
            step(32'h40, 1'b1, 1'b0, 5'd0);
            if (k == 16) begin
                total++; if (a_done !== 1'b0 || a_cycle !== 32'd16) begin bad++; $display("FAIL hang_pre got done=%b cyc=%0d exp 0/16", a_done, a_cycle); end
            end
        end
        total++; if ({a_done, a_pass, a_fail, a_fail_code} !== 5'b10110) begin bad++; $display("FAIL hang_flags got=%b exp=10110", {a_done, a_pass, a_fail, a_fail_code}); end
        total++; if (a_cycle !== 32'd16) begin bad++; $display("FAIL hang_cycle got=%0d exp=16", a_cycle); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(32'h0, 1'b1, 1'b0, 5'd0);
        for (int k = 0; k < 8; k++) begin
            step(32'h100 + 32'(4 * k), 1'b1, 1'b1, 5'd1);
            if (k == 6) begin
                total++; if (b_done !== 1'b0 || b_cycle !== 32'd7) begin bad++; $display("FAIL timeout_pre got done=%b cyc=%0d exp 0/7", b_done, b_cycle); end
            end
        end
        total++; if ({b_done, b_pass, b_fail, b_fail_code} !== 5'b10101) begin bad++; $display("FAIL timeout_flags got=%b exp=10101", {b_done, b_pass, b_fail, b_fail_code}); end
        for (int k = 0; k < 3; k++) step(32'h200 + 32'(4 * k), 1'b1, 1'b1, 5'd1);
        total++; if (b_cycle !== 32'd7 || b_retire !== 32'd7) begin bad++; $display("FAIL timeout_frozen got cyc=%0d ret=%0d exp 7/7", b_cycle, b_retire); end
        total++; if (a_done !== 1'b0 || a_cycle !== 32'd11) begin bad++; $display("FAIL timeout_big got done=%b cyc=%0d exp 0/11", a_done, a_cycle); end
    endtask

    task automatic test_hit_sat();
        do_reset();
        watch_addr = {32'h999, 32'h999, 32'h999, 32'h20};
        step(32'h0, 1'b1, 1'b0, 5'd0);
        for (int k = 0; k < 8; k++) begin
            step((k % 2 == 0) ? 32'h20 : 32'h24, 1'b1, 1'b0, 5'd0);
            if (k == 6) begin
                total++; if (b_hit_count[1:0] !== 2'd3) begin bad++; $display("FAIL hit_sat got=%0d exp=3", b_hit_count[1:0]); end
            end
        end
        total++; if (a_hit_count[15:0] !== 16'd4) begin bad++; $display("FAIL hit_wide got=%0d exp=4", a_hit_count[15:0]); end
        total++; if (b_fail_code !== 2'd1 || b_watch_hit !== '0) begin bad++; $display("FAIL hit_term got code=%0d wh=%b exp 1/0000", b_fail_code, b_watch_hit); end
    endtask

    task automatic test_watch();
        int unsigned expw[NW] = '{3, 3, 3, 0};
        do_reset();
        watch_addr = {32'h1000, 32'h14, 32'h10, 32'h10};
        step(32'h0, 1'b1, 1'b0, 5'd0);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6; k++) begin
                step(32'(4 * k), 1'b1, 1'b0, 5'd0);
                if (r == 1 && k == 4) begin
                    total++; if (a_watch_hit !== 4'b0011) begin bad++; $display("FAIL watch_hit_10 got=%b exp=0011", a_watch_hit); end
                end
                if (r == 1 && k == 5) begin
                    total++; if (a_watch_hit !== 4'b0100) begin bad++; $display("FAIL watch_hit_14 got=%b exp=0100", a_watch_hit); end
                end
            end
        end
        for (int i = 0; i < NW; i++) begin
            total++; if (a_hit_count[i*16 +: 16] !== 16'(expw[i])) begin bad++; $display("FAIL watch_count%0d got=%0d exp=%0d", i, a_hit_count[i*16 +: 16], expw[i]); end
        end
    endtask

    task automatic test_retire_pause();
        logic       rw_t[6] = '{1, 1, 0, 1, 1, 1};
        logic [4:0] wr_t[6] = '{5, 0, 9, 7, 0, 31};
        do_reset();
        watch_addr = {32'h1000, 32'h1000, 32'h1000, 32'h214};
        step(32'h0, 1'b1, 1'b0, 5'd0);
        for (int k = 0; k < 6; k++) step(32'h200 + 32'(4 * k), 1'b1, rw_t[k], wr_t[k]);
        total++; if (a_retire !== 32'd3 || a_cycle !== 32'd6) begin bad++; $display("FAIL retire got ret=%0d cyc=%0d exp 3/6", a_retire, a_cycle); end
        for (int k = 0; k < 4; k++) step(32'h300 + 32'(4 * k), 1'b0, 1'b1, 5'd3);
        total++; if (a_retire !== 32'd3 || a_cycle !== 32'd6) begin bad++; $display("FAIL pause_counts got ret=%0d cyc=%0d exp 3/6", a_retire, a_cycle); end
        total++; if (a_watch_hit !== 4'b0001 || a_hit_count[15:0] !== 16'd1) begin bad++; $display("FAIL pause_watch got wh=%b hc=%0d exp 0001/1", a_watch_hit, a_hit_count[15:0]); end
        step(32'h218, 1'b1, 1'b1, 5'd2);
        total++; if (a_retire !== 32'd4 || a_cycle !== 32'd7 || a_watch_hit !== 4'b0000) begin bad++; $display("FAIL resume got ret=%0d cyc=%0d wh=%b exp 4/7/0000", a_retire, a_cycle, a_watch_hit); end
    endtask

    task automatic test_reset_after_pass();
        do_reset();
        step(32'h0, 1'b1, 1'b0, 5'd0);
        step(32'h4, 1'b1, 1'b1, 5'd4);
        step(HALT, 1'b1, 1'b1, 5'd4);
        total++; if (a_pass !== 1'b1 || a_cycle !== 32'd1 || a_retire !== 32'd1) begin bad++; $display("FAIL rap_pass got pass=%b cyc=%0d ret=%0d exp 1/1/1", a_pass, a_cycle, a_retire); end
        step(32'h0, 1'b1, 1'b0, 5'd0);
        do_reset();
        total++; if ({a_done, a_pass, a_fail, a_fail_code, a_cycle, a_retire} !== '0) begin bad++; $display("FAIL rap_clear got d=%b p=%b cyc=%0d ret=%0d exp all 0", a_done, a_pass, a_cycle, a_retire); end
        step(32'h0, 1'b1, 1'b0, 5'd0);
        total++; if (a_done !== 1'b0 || a_cycle !== 32'd0) begin bad++; $display("FAIL rap_enter got done=%b cyc=%0d exp 0/0", a_done, a_cycle); end
        step(32'h8, 1'b1, 1'b0, 5'd0);
        total++; if (a_cycle !== 32'd1) begin bad++; $display("FAIL rap_restart got=%0d exp=1", a_cycle); end
    endtask

    task automatic test_random();
        logic [31:0] p;
        logic [4:0]  exp_flags;
        int unsigned rep;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            rep = (r % 2 == 1) ? 92 : 20;
            for (int i = 0; i < NW; i++) watch_addr[i*32 +: 32] = 32'(4 * $urandom_range(0, 30));
            if ($urandom_range(0, 1) == 1) watch_addr[63:32] = watch_addr[31:0];
            p = 32'(4 * $urandom_range(0, 30));
            for (int s = 0; s < 80; s++) begin
                if ($urandom_range(0, 99) >= rep) p = 32'(4 * $urandom_range(0, 30));
                step(p, ($urandom_range(0, 99) < 80), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
                exp_flags = {m_st >= 2, m_st == 2, m_st == 3, 2'(m_code)};
                total++; if ({a_done, a_pass, a_fail, a_fail_code} !== exp_flags) begin bad++; $display("FAIL rnd_flags r=%0d s=%0d got=%b exp=%b", r, s, {a_done, a_pass, a_fail, a_fail_code}, exp_flags); end
                total++; if (a_cycle !== 32'(m_hist.size())) begin bad++; $display("FAIL rnd_cycle r=%0d s=%0d got=%0d exp=%0d", r, s, a_cycle, m_hist.size()); end
                total++; if (a_retire !== 32'(m_ret)) begin bad++; $display("FAIL rnd_retire r=%0d s=%0d got=%0d exp=%0d", r, s, a_retire, m_ret); end
                total++; if (a_watch_hit !== ((m_st == 1) ? m_whit : 4'b0)) begin bad++; $display("FAIL rnd_watch_hit r=%0d s=%0d got=%b exp=%b", r, s, a_watch_hit, (m_st == 1) ? m_whit : 4'b0); end
                for (int i = 0; i < NW; i++) begin
                    total++; if (a_hit_count[i*16 +: 16] !== 16'(m_hits[i])) begin bad++; $display("FAIL rnd_hits%0d r=%0d s=%0d got=%0d exp=%0d", i, r, s, a_hit_count[i*16 +: 16], m_hits[i]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_hang();
        test_timeout();
        test_hit_sat();
        test_watch();
        test_retire_pause();
        test_reset_after_pass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
